// File: rtl/rvvi_retire_queue_if.sv
// rvvi_retire_queue_if: producer push side and consumer pop side of the retire-record queue
interface rvvi_retire_queue_if #(
    parameter int XLEN    = 64,
    parameter int ORDER_W = 64
);
    logic               in_valid, in_ready, in_trap;
    logic [ORDER_W-1:0] in_order;
    logic [XLEN-1:0]    in_pc;
    logic [31:0]        in_insn;
    logic [1:0]         in_mode;
    logic               out_valid, out_ready, out_trap;
    logic [ORDER_W-1:0] out_order;
    logic [XLEN-1:0]    out_pc;
    logic [31:0]        out_insn;
    logic [1:0]         out_mode;
    modport slave (
        input  in_valid, in_order, in_pc, in_insn, in_trap, in_mode, out_ready,
        output in_ready, out_valid, out_order, out_pc, out_insn, out_trap, out_mode
    );
    modport master (
        output in_valid, in_order, in_pc, in_insn, in_trap, in_mode, out_ready,
        input  in_ready, out_valid, out_order, out_pc, out_insn, out_trap, out_mode
    );
endinterface

// File: rtl/rvvi_retire_queue.sv
// rvvi_retire_queue: elastic RVVI retire-record FIFO with order continuity check and retire/trap counters
module rvvi_retire_queue #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 8,
    parameter int ORDER_W = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    rvvi_retire_queue_if.slave     q,
    output logic [$clog2(DEPTH):0] count,
    output logic                   order_err,
    output logic [ORDER_W-1:0]     err_order,
    output logic [ORDER_W-1:0]     retire_cnt,
    output logic [ORDER_W-1:0]     trap_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef struct packed {
        logic [ORDER_W-1:0] order;
        logic [XLEN-1:0]    pc;
        logic [31:0]        insn;
        logic               trap;
        logic [1:0]         mode;
    } rec_t;
    rec_t               mem_q [DEPTH];
    rec_t               mem_d [DEPTH];
    rec_t               head;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               first_q, first_d, err_q, err_d;
    logic [ORDER_W-1:0] exp_q, exp_d, err_order_q, err_order_d;
    logic [ORDER_W-1:0] retire_q, retire_d, trap_q, trap_d;
    logic               push, pop, mismatch;
    always_comb begin
        q.in_ready  = cnt_q != CW'(DEPTH);
        q.out_valid = cnt_q != '0;
        push        = q.in_valid & q.in_ready;
        pop         = q.out_valid & q.out_ready;
        head        = q.out_valid ? mem_q[rd_ptr_q] : '0;
        mem_d       = mem_q;
        if (push) mem_d[wr_ptr_q] = {q.in_order, q.in_pc, q.in_insn, q.in_trap, q.in_mode};
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
        // the first record after reset only seeds the expected order
        mismatch    = push & first_q & (q.in_order != exp_q);
        first_d     = first_q | push;
        exp_d       = push ? q.in_order + 1'b1 : exp_q;
        err_d       = err_q | mismatch;
        err_order_d = (mismatch & ~err_q) ? q.in_order : err_order_q;
        retire_d    = retire_q + ORDER_W'(pop & ~head.trap & ~&retire_q);
        trap_d      = trap_q + ORDER_W'(pop & head.trap & ~&trap_q);
        q.out_order = head.order;
        q.out_pc    = head.pc;
        q.out_insn  = head.insn;
        q.out_trap  = head.trap;
        q.out_mode  = head.mode;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            exp_q       <= '0;
            err_q       <= 1'b0;
            err_order_q <= '0;
            retire_q    <= '0;
            trap_q      <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            exp_q       <= exp_d;
            err_q       <= err_d;
            err_order_q <= err_order_d;
            retire_q    <= retire_d;
            trap_q      <= trap_d;
        end
    end
    assign count      = cnt_q;
    assign order_err  = err_q;
    assign err_order  = err_order_q;
    assign retire_cnt = retire_q;
    assign trap_cnt   = trap_q;
endmodule

// File: tb/tb_rvvi_retire_queue.sv
// tb_rvvi_retire_queue: table-driven vectors plus scoreboard-checked directed sequences
module tb_rvvi_retire_queue;
    localparam int XLEN = 64, DEPTH = 8, OW = 64;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    count;
    logic          order_err;
    logic [63:0]   err_order, retire_cnt, trap_cnt;
    always #5 clk = ~clk;
    rvvi_retire_queue_if #(.XLEN(XLEN), .ORDER_W(OW)) q ();
    rvvi_retire_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .ORDER_W(OW)) dut (
        .clk(clk), .reset(reset), .q(q), .count(count), .order_err(order_err),
        .err_order(err_order), .retire_cnt(retire_cnt), .trap_cnt(trap_cnt)
    );
    typedef struct packed {
        logic [63:0] order;
        logic [63:0] pc;
        logic [31:0] insn;
        logic        trap;
        logic [1:0]  mode;
    } rec_t;
    typedef struct packed {
        logic        r, iv, orr;
        logic [63:0] o;
        logic        t;
        logic [3:0]  cnt;
        logic        ir, ov;
        logic [63:0] oo;
        logic [7:0]  ret;
    } vec_t;
    rec_t sb[$];
    vec_t vt[$];
    int   nvec = 0, nerr = 0, npop = 0;

    task automatic chk(string name, logic [199:0] act, logic [199:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(logic [63:0] o, logic t);
        rec_t x;
        x.order = o;
        x.pc    = 64'h8000_0000 + ((o - 64'd5) << 2);
        x.insn  = 32'h13 + (32'(o - 64'd5) << 7);
        x.trap  = t;
        x.mode  = o[1:0];
        return x;
    endfunction

    task automatic drive(logic r, logic iv, logic orr, logic [63:0] o, logic t);
        rec_t x = mk(o, t);
        reset = r; q.in_valid = iv; q.out_ready = orr;
        q.in_order = x.order; q.in_pc = x.pc; q.in_insn = x.insn; q.in_trap = x.trap; q.in_mode = x.mode;
    endtask

    task automatic monitor();
        if (reset) sb.delete();
        else begin
            if (q.out_valid && q.out_ready) begin
                if (sb.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL sb_underflow: got order %0h expected no record", q.out_order);
                end else
                    chk("sb_rec", {q.out_order, q.out_pc, q.out_insn, q.out_trap, q.out_mode}, sb.pop_front());
                npop++;
            end
            if (q.in_valid && q.in_ready) sb.push_back(mk(q.in_order, q.in_trap));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic add(int r, int iv, int orr, logic [63:0] o, int t, int cnt, int ir, int ov, logic [63:0] oo, int ret);
        vec_t v;
        v.r = 1'(r); v.iv = 1'(iv); v.orr = 1'(orr); v.o = o; v.t = 1'(t);
        v.cnt = 4'(cnt); v.ir = 1'(ir); v.ov = 1'(ov); v.oo = oo; v.ret = 8'(ret);
        vt.push_back(v);
    endtask

    initial begin
        rec_t e;
        int   p0;
        drive(1, 0, 0, 0, 0);
        tick();
        add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 5, 0, 1, 1, 1, 5, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 1, 0, k, 0, k, int'(k != 8), 1, 1, 0);
        add(0, 1, 0, 9, 0, 8, 0, 1, 1, 0);
        add(0, 1, 1, 9, 0, 7, 1, 1, 2, 1);
        add(0, 1, 0, 9, 0, 8, 0, 1, 2, 1);
        for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, 0, 8 - k, 1, int'(k != 8), (k == 8) ? 0 : k + 2, 1 + k);
        foreach (vt[i]) begin
            drive(vt[i].r, vt[i].iv, vt[i].orr, vt[i].o, vt[i].t);
            tick();
            e = mk(vt[i].oo, 1'b0);
            chk("count", count, vt[i].cnt);
            chk("in_ready", q.in_ready, vt[i].ir);
            chk("out_valid", q.out_valid, vt[i].ov);
            chk("out_order", q.out_order, vt[i].oo);
            chk("out_pc", q.out_pc, vt[i].ov ? e.pc : 64'd0);
            chk("retire_cnt", retire_cnt, 64'(vt[i].ret));
        end
        drive(1, 0, 0, 0, 0); tick();
        p0 = npop;
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 1, 64'(100 + i), 0); tick();
            chk("stream_count", count, 4'd1);
        end
        drive(0, 0, 1, 0, 0); tick();
        chk("stream_drained", count, 4'd0);
        chk("stream_pops", npop - p0, 20);
        chk("stream_order_err", order_err, 1'b0);
        drive(1, 0, 0, 0, 0); tick();
        p0 = npop;
        drive(0, 1, 1, 10, 0); tick(); chk("gap_err_10", order_err, 1'b0);
        drive(0, 1, 1, 11, 0); tick(); chk("gap_err_11", order_err, 1'b0);
        drive(0, 1, 1, 13, 0); tick(); chk("gap_err_13", order_err, 1'b1);
        chk("gap_err_order_13", err_order, 64'd13);
        drive(0, 1, 1, 15, 0); tick(); chk("gap_err_15", order_err, 1'b1);
        drive(0, 0, 1, 0, 0); tick();
        chk("gap_err_order", err_order, 64'd13);
        chk("gap_pops", npop - p0, 4);
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0); tick();
        drive(0, 1, 0, 0, 0); tick();
        chk("wrap_order_err", order_err, 1'b0);
        chk("wrap_count", count, 4'd2);
        drive(0, 0, 1, 0, 0); tick(); tick();
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 1, 0); tick();
        drive(0, 1, 0, 2, 1); tick();
        drive(0, 1, 0, 3, 0); tick();
        drive(0, 0, 1, 0, 0); tick(); tick();
        chk("trap_retire_cnt", retire_cnt, 64'd1);
        chk("trap_trap_cnt", trap_cnt, 64'd1);
        chk("trap_count", count, 4'd1);
        drive(1, 1, 0, 4, 0); tick();
        chk("rst_count", count, 4'd0);
        chk("rst_out_valid", q.out_valid, 1'b0);
        chk("rst_retire_cnt", retire_cnt, 64'd0);
        chk("rst_trap_cnt", trap_cnt, 64'd0);
        drive(0, 0, 0, 0, 0); tick();
        chk("rst_lost_count", count, 4'd0);
        chk("rst_lost_out_order", q.out_order, 64'd0);
        drive(0, 1, 0, 50, 0); tick();
        drive(0, 1, 1, 51, 0); tick();
        chk("rst_first_seen", order_err, 1'b0);
        drive(0, 0, 1, 0, 0); tick(); tick();
        chk("final_count", count, 4'd0);
        chk("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
